// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator and pwm_capture.
//   PWM_PERIOD  - frame length in clocks
//   PWM_LEVEL_W - width of the duty level byte
//   PWM_CNT_W   - width of the frame/high/run counters (one bit wider than a level)
package pwm_pkg;

    localparam int PWM_PERIOD  = 256;
    localparam int PWM_LEVEL_W = 8;
    localparam int PWM_CNT_W   = 9;

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } cap_state_e;

    // Saturating increment: counters stick at all-ones instead of wrapping,
    // so an overlong frame can never alias back to a legal length.
    function automatic logic [PWM_CNT_W-1:0] sat_inc(input logic [PWM_CNT_W-1:0] v);
        return (&v) ? v : v + PWM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchronizer for an asynchronous single-bit input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d_i   - asynchronous input
//   q_o   - synchronized output, STAGES clocks behind d_i
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// Recovers the duty level of a fixed-frame PWM waveform.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   pwm_in     - raw PWM pin, asynchronous to clk
//   level      - last decoded duty level, held between updates
//   valid      - one-cycle pulse whenever level is written
//   period_err - one-cycle pulse when a rise-to-rise frame is not PERIOD long
//   stuck_high - one-cycle pulse when the input has stayed high for PERIOD clocks
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pwm_in,
    output logic [PWM_LEVEL_W-1:0] level,
    output logic                   valid,
    output logic                   period_err,
    output logic                   stuck_high
);

    localparam logic [PWM_CNT_W-1:0] PERIOD_C = PWM_CNT_W'(PERIOD);
    localparam logic [PWM_CNT_W-1:0] ONE_C    = PWM_CNT_W'(1);

    logic pwm_s;
    logic pwm_d_q;
    logic rise;
    logic change;
    logic timeout;

    cap_state_e             state_q, state_d;
    logic [PWM_CNT_W-1:0]   period_cnt_q, period_cnt_d;
    logic [PWM_CNT_W-1:0]   high_cnt_q, high_cnt_d;
    logic [PWM_CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [PWM_CNT_W-1:0]   run_inc;
    logic [PWM_LEVEL_W-1:0] level_q, level_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   stuck_q, stuck_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (pwm_in),
        .q_o   (pwm_s)
    );

    assign rise    = pwm_s & ~pwm_d_q;
    assign change  = pwm_s ^ pwm_d_q;
    assign run_inc = run_cnt_q + ONE_C;
    // Any edge restarts the run counter, so a timeout can never coincide with a rise.
    assign timeout = ~change && (run_inc == PERIOD_C);

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        level_d      = level_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        stuck_d      = 1'b0;
        run_cnt_d    = (change || timeout) ? '0 : run_inc;

        if (timeout) begin
            // Flat input for a whole frame: report 0% or 100% duty and drop the open frame.
            level_d = pwm_s ? '1 : '0;
            valid_d = 1'b1;
            stuck_d = pwm_s;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        period_cnt_d = ONE_C;
                        high_cnt_d   = ONE_C;
                        state_d      = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        if (period_cnt_q == PERIOD_C) begin
                            // A legal frame has 1..255 high clocks, so the byte slice is exact.
                            level_d = high_cnt_q[PWM_LEVEL_W-1:0];
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        period_cnt_d = ONE_C;
                        high_cnt_d   = ONE_C;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                        if (pwm_s) begin
                            high_cnt_d = sat_inc(high_cnt_q);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pwm_d_q      <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            run_cnt_q    <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_d_q      <= pwm_s;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            run_cnt_q    <= run_cnt_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            stuck_q      <= stuck_d;
        end
    end

    assign level      = level_q;
    assign valid      = valid_q;
    assign period_err = err_q;
    assign stuck_high = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized self-checking bench for pwm_capture. A frame-level reference model
// keeps the synchronized pin history in arrays and derives each report from
// rise-to-rise distances and high-sample sums.
module tb_pwm_capture;

    localparam int PER  = 256;
    localparam int SYNC = 2;
    localparam int HMAX = 16384;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [7:0] level;
    logic       valid;
    logic       period_err;
    logic       stuck_high;

    always #5 clk = ~clk;

    pwm_capture #(.PERIOD(PER), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .level      (level),
        .valid      (valid),
        .period_err (period_err),
        .stuck_high (stuck_high)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit   pin_h [0:HMAX-1];
    bit   s_h   [0:HMAX-1];
    int   cyc;
    bit   m_prev, m_open;
    int   m_lr, m_lc;
    logic [7:0] e_level;
    bit   e_valid, e_err, e_stuck;

    // pin generator: high while frame count < level, level reloads at the wrap
    int gen_lvl, gen_pend, gen_fc;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_prev  = 1'b0;
        m_open  = 1'b0;
        m_lr    = 0;
        m_lc    = -1;
        e_level = 8'h00;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_stuck = 1'b0;
    endtask

    // Decide what the capture reports for cycle 'cyc'; it shows on the outputs one cycle later.
    task automatic model_step(input bit pin);
        bit s;
        int sum;
        if (cyc >= HMAX) begin
            chk("hist_overflow", cyc, HMAX - 1);
            return;
        end
        pin_h[cyc] = pin;
        s = (cyc >= SYNC) ? pin_h[cyc - SYNC] : 1'b0;
        s_h[cyc] = s;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_stuck = 1'b0;
        if (s && !m_prev) begin
            if (m_open && (cyc - m_lr == PER)) begin
                sum = 0;
                for (int i = m_lr; i < cyc; i++) sum += int'(s_h[i]);
                e_level = sum[7:0];
                e_valid = 1'b1;
            end else if (m_open) begin
                e_err = 1'b1;
            end
            m_open = 1'b1;
            m_lr   = cyc;
            m_lc   = cyc;
        end else if (s != m_prev) begin
            m_lc = cyc;
        end else if (cyc - m_lc == PER) begin
            e_level = s ? 8'hFF : 8'h00;
            e_valid = 1'b1;
            e_stuck = s;
            m_open  = 1'b0;
            m_lc    = cyc;
        end
        m_prev = s;
    endtask

    task automatic check_outs();
        chk("level",      int'(level),      int'(e_level));
        chk("valid",      int'(valid),      int'(e_valid));
        chk("period_err", int'(period_err), int'(e_err));
        chk("stuck_high", int'(stuck_high), int'(e_stuck));
    endtask

    task automatic tick(input bit pin);
        @(posedge clk);
        #1;
        cyc++;
        check_outs();
        pwm_in = pin;
        model_step(pin);
    endtask

    function automatic bit gen_pin();
        return gen_fc < gen_lvl;
    endfunction

    task automatic gen_adv();
        gen_fc = (gen_fc + 1) % PER;
        if (gen_fc == 0) gen_lvl = gen_pend;
    endtask

    task automatic gen_tick();
        tick(gen_pin());
        gen_adv();
    endtask

    task automatic run_gen(input int n);
        for (int i = 0; i < n; i++) gen_tick();
    endtask

    // Assert reset right here (between edges), check the outputs clear at once,
    // hold a few clocks, then release and restart the model from cycle 0.
    task automatic do_reset();
        bit p;
        reset = 1'b0;
        #1;
        chk("rst_level",      int'(level),      0);
        chk("rst_valid",      int'(valid),      0);
        chk("rst_period_err", int'(period_err), 0);
        chk("rst_stuck_high", int'(stuck_high), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        p = gen_pin();
        pwm_in = p;
        model_step(p);
        gen_adv();
    endtask

    task automatic set_gen(input int lvl, input int fc);
        gen_lvl  = lvl;
        gen_pend = lvl;
        gen_fc   = fc;
    endtask

    initial begin
        reset  = 1'b0;
        pwm_in = 1'b0;
        model_reset();

        // level 128: first report after the second rise, then every frame
        set_gen(128, 0);
        do_reset();
        run_gen(5 * PER);

        // level 0: timeout path reports 0 every frame
        set_gen(0, 0);
        do_reset();
        run_gen(4 * PER + 10);

        // level 1, then 255 switched at a frame wrap
        set_gen(1, 0);
        do_reset();
        run_gen(3 * PER);
        gen_pend = 255;
        run_gen(4 * PER);

        // constant high: stuck_high with level FF every frame
        set_gen(PER, 0);
        do_reset();
        run_gen(4 * PER + 10);

        // rises 200 clocks apart: period_err each time, level held
        set_gen(0, 0);
        do_reset();
        for (int k = 0; k < 6 * 200; k++) tick((k % 200) < 20);

        // reset 100 clocks into a level-64 frame, then recover
        set_gen(64, 0);
        do_reset();
        run_gen(2 * PER + 100);
        do_reset();
        run_gen(4 * PER);

        // random levels per frame with random starting phase, biased toward the extremes
        set_gen(int'($urandom_range(0, 255)), int'($urandom_range(0, PER - 1)));
        do_reset();
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 7))
                0:       gen_pend = 0;
                1:       gen_pend = 255;
                default: gen_pend = int'($urandom_range(1, 254));
            endcase
            run_gen(PER);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
